// File: rtl/spike_aer_encoder.sv
// Address-event encoder: latches spikes into a pending vector, picks one per cycle
// round-robin, and queues {neuron_id, timestamp} events in a show-ahead FIFO.
module spike_aer_encoder #(
    parameter int NUM_NEURONS = 8,
    parameter int ID_WIDTH    = 3,
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   timestep_tick,
    input  logic                   clear_overflow,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ID_WIDTH-1:0]    aer_neuron_id,
    output logic [TS_WIDTH-1:0]    aer_timestamp,
    output logic [FIFO_AW:0]       fifo_count,
    output logic                   overflow,
    output logic                   busy
);

    localparam int EW = ID_WIDTH + TS_WIDTH;
    localparam logic [FIFO_AW:0]  LP_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [ID_WIDTH:0] LP_N     = (ID_WIDTH+1)'(NUM_NEURONS);

    logic [NUM_NEURONS-1:0] r_pending;
    logic [ID_WIDTH-1:0]    r_ptr;
    logic [TS_WIDTH-1:0]    r_ts;
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [FIFO_AW:0]       r_count;
    logic                   r_overflow;
    logic [EW-1:0]          r_mem [FIFO_DEPTH];

    logic [2*NUM_NEURONS-1:0] w_rot_full;
    logic [NUM_NEURONS-1:0]   w_rot;
    logic [NUM_NEURONS-1:0]   w_rot_onehot;
    logic [ID_WIDTH-1:0]      w_offset;
    logic [ID_WIDTH:0]        w_sum;
    logic [ID_WIDTH-1:0]      w_grant_id;
    logic [NUM_NEURONS-1:0]   w_grant;
    logic                     w_grant_valid;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic [EW-1:0]            w_head;

    // Rotate pending so the priority neuron sits at bit 0; the lowest set bit
    // of the rotated vector is then the round-robin winner.
    assign w_rot_full   = {r_pending, r_pending} >> r_ptr;
    assign w_rot        = w_rot_full[NUM_NEURONS-1:0];
    assign w_rot_onehot = w_rot & (~w_rot + NUM_NEURONS'(1));

    always_comb begin
        w_offset = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (w_rot_onehot[k]) begin
                w_offset = w_offset | ID_WIDTH'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_grant_id = (w_sum >= LP_N) ? ID_WIDTH'(w_sum - LP_N) : w_sum[ID_WIDTH-1:0];

    assign w_full        = (r_count == LP_DEPTH);
    assign w_grant_valid = enable && !w_full && (r_pending != '0);

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_grant
            assign w_grant[gi] = w_grant_valid && (w_grant_id == ID_WIDTH'(gi));
        end
    endgenerate

    assign w_push = w_grant_valid;
    assign w_pop  = (r_count != '0) && aer_ready;
    // A granted neuron may re-spike in the same cycle without losing anything.
    assign w_drop = enable && ((spike_in & r_pending & ~w_grant) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (enable) begin
                r_pending <= (r_pending & ~w_grant) | spike_in;
                if (timestep_tick) begin
                    r_ts <= r_ts + TS_WIDTH'(1);
                end
            end
            if (w_grant_valid) begin
                r_ptr <= (w_grant_id == ID_WIDTH'(NUM_NEURONS - 1)) ? '0
                                                                     : w_grant_id + ID_WIDTH'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage carries no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_grant_id, r_ts};
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign aer_valid     = (r_count != '0);
    assign aer_neuron_id = aer_valid ? w_head[EW-1:TS_WIDTH] : '0;
    assign aer_timestamp = aer_valid ? w_head[TS_WIDTH-1:0] : '0;
    assign fifo_count    = r_count;
    assign overflow      = r_overflow;
    assign busy          = (r_pending != '0) || (r_count != '0);

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameters SHALL be: NUM_NEURONS, default 8, number of spike inputs; ID_WIDTH, default 3, neuron-ID width (2^ID_WIDTH >= NUM_NEURONS); TS_WIDTH, default 16, timestamp width; FIFO_DEPTH, default 16, event FIFO depth (power of 2); FIFO_AW, default 4, log2(FIFO_DEPTH).
REQ-002 Ports SHALL be, one per line, name direction width meaning:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  high = sample spikes, arbitrate, count timesteps
- spike_in  input  NUM_NEURONS  one-cycle spike_out pulses from lif_neuron instances, bit i = neuron i
- timestep_tick  input  1  one-cycle pulse advancing the timestamp counter
- clear_overflow  input  1  clears the overflow flag
- aer_valid  output  1  FIFO head event available
- aer_ready  input  1  consumer accepts head event
- aer_neuron_id  output  ID_WIDTH  neuron ID of head event
- aer_timestamp  output  TS_WIDTH  timestamp of head event
- fifo_count  output  FIFO_AW+1  events stored, 0..FIFO_DEPTH
- overflow  output  1  sticky: at least one spike dropped
- busy  output  1  high when pending bits or FIFO non-empty

Function
REQ-003 The block SHALL hold a NUM_NEURONS-bit pending register; with enable high, each edge: pending <= (pending & ~grant) | spike_in.
REQ-004 A spike on neuron i while pending[i]=1 and neuron i not granted that cycle SHALL be dropped and SHALL set overflow.
REQ-005 A spike on neuron i in the same cycle that neuron i is granted SHALL leave pending[i]=1, without setting overflow.
REQ-006 The arbiter SHALL be round-robin: at most one one-hot grant per cycle, issued only when enable=1, pending!=0 and fifo_count<FIFO_DEPTH.
REQ-007 Priority pointer SHALL reset to 0; after a grant to neuron i the first-priority neuron SHALL be (i+1) mod NUM_NEURONS.
REQ-008 A grant SHALL write {i, ts_counter} into the FIFO on that edge; ts_counter is the value before any same-cycle increment.
REQ-009 ts_counter SHALL increment by 1 on each edge with enable=1 and timestep_tick=1, wrapping 2^TS_WIDTH-1 -> 0.
REQ-010 aer_valid SHALL equal (fifo_count!=0); aer_neuron_id/aer_timestamp SHALL present the FIFO head combinationally from registered storage (show-ahead).
REQ-011 The head SHALL be popped on an edge with aer_valid=1 and aer_ready=1, independent of enable.
REQ-012 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-013 aer_ready while aer_valid=0 SHALL have no effect; the head SHALL stay stable while aer_valid=1 and aer_ready=0.
REQ-014 Latency: spike_in high before edge k -> pending at k -> FIFO write at k+1 (if granted) -> aer_valid high after k+1 when FIFO was empty.
REQ-015 With FIFO full, pending bits SHALL be held (no grant); only further spikes on held neurons drop per REQ-004.
REQ-016 enable=0 SHALL freeze pending, pointer and ts_counter, ignore spike_in and timestep_tick, and still allow FIFO drain.
REQ-017 overflow SHALL clear on clear_overflow=1; a same-cycle drop SHALL win (overflow stays 1).
REQ-018 busy SHALL equal (pending!=0) | (fifo_count!=0).

Reset
REQ-019 rst_n=0 SHALL asynchronously clear pending, pointer, ts_counter, FIFO pointers, fifo_count and overflow; aer_valid=0, aer_neuron_id=0, aer_timestamp=0, busy=0.
REQ-020 Reset mid-operation SHALL discard all pending and queued events; none emitted after release.

Verification
REQ-021 Single spike: enable=1, aer_ready=1, ts=0, spike_in=8'h04 one cycle -> two edges later aer_valid=1, id=2, timestamp=0, popped next edge, fifo_count back to 0.
REQ-022 Round-robin: spike_in=8'hFF one cycle, aer_ready=1 -> ids 0,1,...,7 on consecutive cycles, overflow=0.
REQ-023 Backpressure/full: aer_ready=0, spike_in toggled to give 20 distinct-neuron events over time -> fifo_count saturates at 16, remaining held in pending; spike on a held neuron sets overflow=1; aer_ready=1 drains all in order.
REQ-024 Timestamp wrap: TS_WIDTH=4, 15 ticks then spike on neuron 5 -> timestamp=15; one more tick then spike -> timestamp=0.
REQ-025 Enable/reset: enable=0 with spike_in=8'h01 -> no event, pending=0; queue 3 events, assert rst_n=0 mid-drain -> aer_valid=0 immediately, fifo_count=0, nothing emitted after release.
